// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if -- ID-stage hazard interface.
//   master : decode side, drives the ID instruction fields, flow_change and cond_fail,
//            and receives the stall, kill, bypass, halt and busy outputs.
//   slave  : the hazard_ctrl block.
//   Fields : id_valid, id_re0/1, id_p0/1_addr[AW], id_we, id_dst[AW], id_is_load,
//            id_hlt, flow_change, cond_fail -> stall_if, kill_id,
//            byp0/1_sel[DEPTH], hlt_wb, busy.
interface hazard_ctrl_if #(
  parameter int AW    = 6,
  parameter int DEPTH = 3
);
  logic             id_valid;
  logic             id_re0, id_re1;
  logic [AW-1:0]    id_p0_addr, id_p1_addr;
  logic             id_we;
  logic [AW-1:0]    id_dst;
  logic             id_is_load;
  logic             id_hlt;
  logic             flow_change;
  logic             cond_fail;
  logic             stall_if;
  logic             kill_id;
  logic [DEPTH-1:0] byp0_sel, byp1_sel;
  logic             hlt_wb;
  logic             busy;

  modport master (
    output id_valid, id_re0, id_re1, id_p0_addr, id_p1_addr, id_we, id_dst,
           id_is_load, id_hlt, flow_change, cond_fail,
    input  stall_if, kill_id, byp0_sel, byp1_sel, hlt_wb, busy
  );
  modport slave (
    input  id_valid, id_re0, id_re1, id_p0_addr, id_p1_addr, id_we, id_dst,
           id_is_load, id_hlt, flow_change, cond_fail,
    output stall_if, kill_id, byp0_sel, byp1_sel, hlt_wb, busy
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller: RAW scoreboard, load-use stall,
// bypass select, flow-change flush and halt tracking.
//   clk, rst_n : clock, asynchronous active-low reset
//   hz (slave) : ID instruction fields in; stall_if, kill_id, byp0/1_sel,
//                hlt_wb and busy out (see hazard_ctrl_if).
// Build option: define CISCV_HAZ_BYPASS_EN for bypass plus load-use stall.
// When it is left undefined, the selects are tied to zero and any RAW match
// against an in-flight entry interlocks.
module hazard_ctrl #(
  parameter int AW        = 6,
  parameter int DEPTH     = 3,
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_CYC = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave hz
);
  localparam int CW = 3;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] dst;
    logic          is_load;
  } sb_ent_t;

  if (DEPTH < 2 || DEPTH > 8 || LOAD_LAT < 1 || LOAD_LAT > DEPTH-1 ||
      FLUSH_CYC < 1 || FLUSH_CYC > 4) begin : g_param_err
    $error("hazard_ctrl: illegal parameter combination");
  end

  sb_ent_t [DEPTH-1:0] sb_q;
  logic    [DEPTH-1:0] m0, m1;
  logic    [DEPTH-1:0] hpipe_q;   // bit 0 doubles as the sticky halt
  logic    [CW-1:0]    cnt_q, cnt_d;
  logic                flush_kill, ldu, stall, kill, accept, busy;

  // RAW match of each ID operand against each in-flight entry; R0 never matches.
  always_comb begin
    m0   = '0;
    m1   = '0;
    busy = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      m0[k] = sb_q[k].we && (sb_q[k].dst == hz.id_p0_addr) &&
              (hz.id_p0_addr != '0) && hz.id_re0;
      m1[k] = sb_q[k].we && (sb_q[k].dst == hz.id_p1_addr) &&
              (hz.id_p1_addr != '0) && hz.id_re1;
      busy  = busy | sb_q[k].we;
    end
  end

`ifdef CISCV_HAZ_BYPASS_EN
  logic [DEPTH-1:0] y0, y1, byp0_q, byp1_q;
  logic             ld0, ld1;

  // Scan from oldest to youngest so the youngest match wins. A stall is needed
  // only when that youngest producer is a load whose data is not yet bypassable.
  always_comb begin
    y0  = '0;
    y1  = '0;
    ld0 = 1'b0;
    ld1 = 1'b0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (m0[k]) begin
        y0    = '0;
        y0[k] = 1'b1;
        ld0   = sb_q[k].is_load && (k < LOAD_LAT);
      end
      if (m1[k]) begin
        y1    = '0;
        y1[k] = 1'b1;
        ld1   = sb_q[k].is_load && (k < LOAD_LAT);
      end
    end
  end

  assign ldu = ld0 | ld1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp0_q <= '0;
      byp1_q <= '0;
    end else begin
      byp0_q <= kill ? '0 : y0;
      byp1_q <= kill ? '0 : y1;
    end
  end

  assign hz.byp0_sel = byp0_q;
  assign hz.byp1_sel = byp1_q;
`else
  logic [DEPTH-1:0] unused_ld;

  always_comb begin
    unused_ld = '0;
    for (int k = 0; k < DEPTH; k++) unused_ld[k] = sb_q[k].is_load;
  end

  assign ldu         = |{m0, m1};
  assign hz.byp0_sel = '0;
  assign hz.byp1_sel = '0;
`endif

  // A flush takes priority over a stall, so the fetch redirect is not held.
  // A halt overrides both.
  assign flush_kill = hz.flow_change | (cnt_q != '0);
  assign stall      = hpipe_q[0] | (ldu & ~flush_kill);
  assign kill       = hpipe_q[0] | flush_kill | ldu;
  assign accept     = hz.id_hlt & hz.id_valid & ~kill;

  always_comb begin
    cnt_d = cnt_q;
    if (hz.flow_change)   cnt_d = CW'(FLUSH_CYC - 1);
    else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q    <= '0;
      cnt_q   <= '0;
      hpipe_q <= '0;
    end else begin
      sb_q[0] <= {hz.id_we & hz.id_valid & ~kill & ~stall, hz.id_dst, hz.id_is_load};
      for (int k = 1; k < DEPTH; k++) sb_q[k] <= sb_q[k-1];
      if (hz.cond_fail) sb_q[1].we <= 1'b0;
      cnt_q   <= cnt_d;
      // Each stage is fed by a stage that never clears, so the halt stays set at every stage.
      hpipe_q <= {hpipe_q[DEPTH-2:0], hpipe_q[0] | accept};
    end
  end

  assign hz.stall_if = stall;
  assign hz.kill_id  = kill;
  assign hz.hlt_wb   = hpipe_q[DEPTH-1];
  assign hz.busy     = busy;
endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.AW(6), .DEPTH(3)) hz ();
  hazard_ctrl #(.AW(6), .DEPTH(3), .LOAD_LAT(1), .FLUSH_CYC(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hz.id_valid = 0; hz.id_re0 = 0; hz.id_re1 = 0;
    hz.id_p0_addr = '0; hz.id_p1_addr = '0;
    hz.id_we = 0; hz.id_dst = '0; hz.id_is_load = 0; hz.id_hlt = 0;
    hz.flow_change = 0; hz.cond_fail = 0;
  endtask

  // Producer: writes dst, optionally a load.
  task automatic prod(input logic [5:0] dst, input logic ld);
    idle();
    hz.id_valid = 1; hz.id_we = 1; hz.id_dst = dst; hz.id_is_load = ld;
  endtask

  // Consumer: reads p0 / p1 under their read enables, no write.
  task automatic cons(input logic re0, input logic [5:0] p0,
                      input logic re1, input logic [5:0] p1);
    idle();
    hz.id_valid = 1; hz.id_re0 = re0; hz.id_p0_addr = p0;
    hz.id_re1 = re1; hz.id_p1_addr = p1;
  endtask

  task automatic drain();
    idle();
    repeat (4) tick();
  endtask

  initial begin
    idle();
    #1;
    chk("rst_stall", 32'(hz.stall_if), 0);
    chk("rst_kill",  32'(hz.kill_id), 0);
    chk("rst_byp0",  32'(hz.byp0_sel), 0);
    chk("rst_byp1",  32'(hz.byp1_sel), 0);
    chk("rst_hltwb", 32'(hz.hlt_wb), 0);
    chk("rst_busy",  32'(hz.busy), 0);
    tick(); tick();
    rst_n = 1;
    tick();

    // ADD R5 followed by a reader of R5
    prod(6'd5, 0); #1;
    chk("a_c0_stall", 32'(hz.stall_if), 0);
    tick();
    cons(1, 6'd5, 0, 6'd0); #1;
    chk("a_c1_busy", 32'(hz.busy), 1);
`ifdef CISCV_HAZ_BYPASS_EN
    chk("a_c1_stall", 32'(hz.stall_if), 0);
    chk("a_c1_kill",  32'(hz.kill_id), 0);
    tick(); idle(); #1;
    chk("a_c2_byp0", 32'(hz.byp0_sel), 32'b001);
    tick(); #1;
    chk("a_c3_byp0", 32'(hz.byp0_sel), 0);
`else
    chk("a_c1_stall", 32'(hz.stall_if), 1);
    chk("a_c1_kill",  32'(hz.kill_id), 1);
    tick();
    chk("a_c2_stall", 32'(hz.stall_if), 1);
    chk("a_c2_byp0",  32'(hz.byp0_sel), 0);
    tick();
    chk("a_c3_stall", 32'(hz.stall_if), 1);
    tick();
    chk("a_c4_stall", 32'(hz.stall_if), 0);
    chk("a_c4_kill",  32'(hz.kill_id), 0);
    chk("a_c4_busy",  32'(hz.busy), 0);
`endif
    drain();

`ifdef CISCV_HAZ_BYPASS_EN
    // LW R7 then reader of R7 on operand 1: one stall, then bypass from stage 1
    prod(6'd7, 1); tick();
    cons(0, 6'd0, 1, 6'd7); #1;
    chk("l_c1_stall", 32'(hz.stall_if), 1);
    chk("l_c1_kill",  32'(hz.kill_id), 1);
    tick();
    chk("l_c2_stall", 32'(hz.stall_if), 0);
    chk("l_c2_byp1",  32'(hz.byp1_sel), 0);
    tick(); idle(); #1;
    chk("l_c3_byp1", 32'(hz.byp1_sel), 32'b010);
    drain();
`endif

    // R0 destination in flight never creates a hazard
    prod(6'd0, 0); tick();
    cons(1, 6'd0, 1, 6'd0); #1;
    chk("r0_stall", 32'(hz.stall_if), 0);
    chk("r0_kill",  32'(hz.kill_id), 0);
    chk("r0_busy",  32'(hz.busy), 1);
    tick(); idle(); #1;
    chk("r0_byp0", 32'(hz.byp0_sel), 0);
    drain();

    // Address matches but read enable is low
    prod(6'd9, 0); tick();
    cons(1, 6'd3, 0, 6'd9); #1;
    chk("ren_stall", 32'(hz.stall_if), 0);
    drain();

    // cond_fail clears the producer's write as it leaves stage 0
    prod(6'd12, 0); tick();
    cons(1, 6'd12, 0, 6'd0); hz.cond_fail = 1; #1;
`ifdef CISCV_HAZ_BYPASS_EN
    chk("cf_c1_stall", 32'(hz.stall_if), 0);
    tick(); hz.cond_fail = 0; #1;
    chk("cf_c2_byp0", 32'(hz.byp0_sel), 32'b001);
    chk("cf_c2_busy", 32'(hz.busy), 0);
    tick(); #1;
    chk("cf_c3_byp0", 32'(hz.byp0_sel), 0);
`else
    chk("cf_c1_stall", 32'(hz.stall_if), 1);
    tick(); hz.cond_fail = 0; #1;
    chk("cf_c2_stall", 32'(hz.stall_if), 0);
    chk("cf_c2_busy",  32'(hz.busy), 0);
`endif
    drain();

    // flow_change while a load-use hazard is pending: kill without stall
    prod(6'd7, 1); tick();
    cons(0, 6'd0, 1, 6'd7); hz.flow_change = 1; #1;
    chk("fl_c1_kill",  32'(hz.kill_id), 1);
    chk("fl_c1_stall", 32'(hz.stall_if), 0);
    tick(); hz.flow_change = 0; #1;
    chk("fl_c2_kill",  32'(hz.kill_id), 1);
    chk("fl_c2_stall", 32'(hz.stall_if), 0);
    tick();
`ifdef CISCV_HAZ_BYPASS_EN
    chk("fl_c3_kill", 32'(hz.kill_id), 0);
    chk("fl_c3_byp1", 32'(hz.byp1_sel), 0);
`else
    chk("fl_c3_kill", 32'(hz.kill_id), 1);
`endif
    drain();

    // Single flow_change pulse: exactly two killed slots
    hz.flow_change = 1; #1;
    chk("fp_c0_kill", 32'(hz.kill_id), 1);
    tick(); hz.flow_change = 0; #1;
    chk("fp_c1_kill", 32'(hz.kill_id), 1);
    tick();
    chk("fp_c2_kill", 32'(hz.kill_id), 0);
    drain();

    // Second flow_change during the count reloads it
    hz.flow_change = 1; tick(); #1;
    chk("fr_c1_kill", 32'(hz.kill_id), 1);
    tick(); hz.flow_change = 0; #1;
    chk("fr_c2_kill", 32'(hz.kill_id), 1);
    tick();
    chk("fr_c3_kill", 32'(hz.kill_id), 0);
    drain();

    // Reset in the middle of a load-use stall aborts it
    prod(6'd5, 1); tick();
    cons(1, 6'd5, 0, 6'd0); #1;
    chk("rs_stall_pre", 32'(hz.stall_if), 1);
    rst_n = 0; #1;
    chk("rs_stall", 32'(hz.stall_if), 0);
    chk("rs_kill",  32'(hz.kill_id), 0);
    chk("rs_busy",  32'(hz.busy), 0);
    tick(); rst_n = 1; #1;
    chk("rs_rel_stall", 32'(hz.stall_if), 0);
    drain();

    // HLT accepted at t: stall from t+1, hlt_wb at t+3 and held
    idle(); hz.id_valid = 1; hz.id_hlt = 1; #1;
    chk("h_t0_stall", 32'(hz.stall_if), 0);
    chk("h_t0_kill",  32'(hz.kill_id), 0);
    tick(); idle(); #1;
    chk("h_t1_stall", 32'(hz.stall_if), 1);
    chk("h_t1_kill",  32'(hz.kill_id), 1);
    chk("h_t1_hltwb", 32'(hz.hlt_wb), 0);
    tick();
    chk("h_t2_hltwb", 32'(hz.hlt_wb), 0);
    tick();
    chk("h_t3_hltwb", 32'(hz.hlt_wb), 1);
    tick();
    chk("h_t4_hltwb", 32'(hz.hlt_wb), 1);
    chk("h_t4_stall", 32'(hz.stall_if), 1);
    rst_n = 0; #1;
    chk("h_rst_stall", 32'(hz.stall_if), 0);
    chk("h_rst_hltwb", 32'(hz.hlt_wb), 0);
    tick(); rst_n = 1; #1;
    chk("h_rel_kill", 32'(hz.kill_id), 0);

    // HLT accepted, reset at t+1 wipes the halt before it reaches write-back
    hz.id_valid = 1; hz.id_hlt = 1; tick(); idle(); #1;
    chk("hr_t1_stall_pre", 32'(hz.stall_if), 1);
    rst_n = 0; #1;
    chk("hr_stall", 32'(hz.stall_if), 0);
    chk("hr_kill",  32'(hz.kill_id), 0);
    chk("hr_hltwb", 32'(hz.hlt_wb), 0);
    chk("hr_busy",  32'(hz.busy), 0);
    tick(); rst_n = 1; #1;
    chk("hr_rel_stall", 32'(hz.stall_if), 0);
    tick(); tick(); tick();
    chk("hr_late_hltwb", 32'(hz.hlt_wb), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
